// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for mem_port_arbiter: port 0 (fetch) and port 1 (load/store).
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_ack;
   logic [DATA_W-1:0] p0_rdata;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_ack;
   logic [DATA_W-1:0] p1_rdata;

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_ack, p0_rdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p1_ack, p1_rdata
   );

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_ack, p0_rdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p1_ack, p1_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for a single-port synchronous memory: one access per
// IDLE->ISSUE->CAPTURE->DONE pass, registered outputs, one-cycle ack per access.
module mem_port_arbiter #(
   parameter int ADDR_W         = 12,
   parameter int DATA_W         = 32,
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus,
   output logic              o_mem_en,
   output logic              o_mem_read_write,
   output logic [ADDR_W-1:0] o_mem_address,
   output logic [DATA_W-1:0] o_mem_data_in,
   input  logic [DATA_W-1:0] i_mem_data_out,
   output logic              o_busy,
   output logic              o_grant_id
);
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE, ST_DONE} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_last_grant;
   logic              r_is_write;
   logic              r_mem_en;
   logic              r_mem_rw;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_din;
   logic              r_busy;
   logic              r_grant_id;
   logic              r_p0_ack;
   logic              r_p1_ack;
   logic [DATA_W-1:0] r_p0_rdata;
   logic [DATA_W-1:0] r_p1_rdata;
   logic              w_any_req;
   logic              w_win_id;

   // On a tie, round-robin favours the port that did not win last time.
   always_comb begin
      w_any_req = bus.p0_req | bus.p1_req;
      w_win_id  = bus.p1_req;
      if (bus.p0_req && bus.p1_req) begin
         w_win_id = FIXED_PRIORITY ? 1'b0 : ~r_last_grant;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:    if (w_any_req) w_next_state = ST_ISSUE;
         ST_ISSUE:   w_next_state = ST_CAPTURE;
         ST_CAPTURE: w_next_state = ST_DONE;
         ST_DONE:    w_next_state = ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_is_write   <= 1'b0;
         r_mem_en     <= 1'b0;
         r_mem_rw     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_din    <= '0;
         r_busy       <= 1'b0;
         r_grant_id   <= 1'b0;
         r_p0_ack     <= 1'b0;
         r_p1_ack     <= 1'b0;
         r_p0_rdata   <= '0;
         r_p1_rdata   <= '0;
      end else begin
         r_p0_ack <= 1'b0;
         r_p1_ack <= 1'b0;
         r_busy   <= (w_next_state != ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_grant_id   <= w_win_id;
                  r_last_grant <= w_win_id;
                  r_mem_en     <= 1'b1;
                  r_mem_rw     <= w_win_id ? bus.p1_we    : bus.p0_we;
                  r_is_write   <= w_win_id ? bus.p1_we    : bus.p0_we;
                  r_mem_addr   <= w_win_id ? bus.p1_addr  : bus.p0_addr;
                  r_mem_din    <= w_win_id ? bus.p1_wdata : bus.p0_wdata;
               end else begin
                  r_mem_en <= 1'b0;
                  r_mem_rw <= 1'b0;
               end
            end
            ST_ISSUE: begin
               r_mem_en <= 1'b0;
               r_mem_rw <= 1'b0;
            end
            ST_CAPTURE: begin
               // Read data is only valid (driven) in this state, and only after a read.
               if (r_grant_id) begin
                  r_p1_ack <= 1'b1;
                  if (!r_is_write) r_p1_rdata <= i_mem_data_out;
               end else begin
                  r_p0_ack <= 1'b1;
                  if (!r_is_write) r_p0_rdata <= i_mem_data_out;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_mem_en         = r_mem_en;
   assign o_mem_read_write = r_mem_rw;
   assign o_mem_address    = r_mem_addr;
   assign o_mem_data_in    = r_mem_din;
   assign o_busy           = r_busy;
   assign o_grant_id       = r_grant_id;
   assign bus.p0_ack       = r_p0_ack;
   assign bus.p1_ack       = r_p1_ack;
   assign bus.p0_rdata     = r_p0_rdata;
   assign bus.p1_rdata     = r_p1_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a round-robin and a fixed-priority instance,
// each on a synchronous memory model whose read port is tri-stated outside CAPTURE.
module tb_mem_port_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;

   typedef struct {
      logic [DW-1:0] rdata;
      int            due;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[4][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_rr ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fx ();

   logic          rr_mem_en, rr_rw, rr_busy, rr_grant;
   logic [AW-1:0] rr_addr;
   logic [DW-1:0] rr_din;
   wire  [DW-1:0] rr_dout;
   logic          fx_mem_en, fx_rw, fx_busy, fx_grant;
   logic [AW-1:0] fx_addr;
   logic [DW-1:0] fx_din;
   wire  [DW-1:0] fx_dout;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIORITY(1'b0)) u_rr (
      .clk(clk), .rst_n(rst_n), .bus(bus_rr),
      .o_mem_en(rr_mem_en), .o_mem_read_write(rr_rw), .o_mem_address(rr_addr),
      .o_mem_data_in(rr_din), .i_mem_data_out(rr_dout),
      .o_busy(rr_busy), .o_grant_id(rr_grant)
   );

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIORITY(1'b1)) u_fx (
      .clk(clk), .rst_n(rst_n), .bus(bus_fx),
      .o_mem_en(fx_mem_en), .o_mem_read_write(fx_rw), .o_mem_address(fx_addr),
      .o_mem_data_in(fx_din), .i_mem_data_out(fx_dout),
      .o_busy(fx_busy), .o_grant_id(fx_grant)
   );

   // Memory models: registered read, output driven only in the cycle after a read edge.
   logic [DW-1:0] rr_mem [4096];
   logic [DW-1:0] rr_q;
   logic          rr_oe = 1'b0;
   logic [DW-1:0] fx_mem [4096];
   logic [DW-1:0] fx_q;
   logic          fx_oe = 1'b0;

   always @(posedge clk) begin
      rr_oe <= rr_mem_en && !rr_rw;
      if (rr_mem_en) begin
         if (rr_rw) rr_mem[rr_addr] <= rr_din;
         else       rr_q <= rr_mem[rr_addr];
      end
      fx_oe <= fx_mem_en && !fx_rw;
      if (fx_mem_en) begin
         if (fx_rw) fx_mem[fx_addr] <= fx_din;
         else       fx_q <= fx_mem[fx_addr];
      end
   end

   assign rr_dout = rr_oe ? rr_q : {DW{1'bz}};
   assign fx_dout = fx_oe ? fx_q : {DW{1'bz}};

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic ack_of(int k);
      case (k)
         0:       return bus_rr.p0_ack;
         1:       return bus_rr.p1_ack;
         2:       return bus_fx.p0_ack;
         default: return bus_fx.p1_ack;
      endcase
   endfunction

   function automatic logic [DW-1:0] rd_of(int k);
      case (k)
         0:       return bus_rr.p0_rdata;
         1:       return bus_rr.p1_rdata;
         2:       return bus_fx.p0_rdata;
         default: return bus_fx.p1_rdata;
      endcase
   endfunction

   task automatic drive(int k, logic req, logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
      case (k)
         0: begin bus_rr.p0_req = req; bus_rr.p0_we = we; bus_rr.p0_addr = a; bus_rr.p0_wdata = wd; end
         1: begin bus_rr.p1_req = req; bus_rr.p1_we = we; bus_rr.p1_addr = a; bus_rr.p1_wdata = wd; end
         2: begin bus_fx.p0_req = req; bus_fx.p0_we = we; bus_fx.p0_addr = a; bus_fx.p0_wdata = wd; end
         default: begin bus_fx.p1_req = req; bus_fx.p1_we = we; bus_fx.p1_addr = a; bus_fx.p1_wdata = wd; end
      endcase
   endtask

   // Presents one transaction, queues its expected result, holds req until ack, then drops it.
   task automatic txn(int k, logic we, logic [AW-1:0] a, logic [DW-1:0] wd,
                      logic [DW-1:0] exp_rd, int lat);
      exp_t e;
      int   n = 0;
      drive(k, 1'b1, we, a, wd);
      e.rdata = exp_rd;
      e.due   = cyc + lat;
      exp_q[k].push_back(e);
      do begin
         @(negedge clk);
         n++;
      end while (!ack_of(k) && n < 40);
      check($sformatf("ack_seen_k%0d", k), 32'(ack_of(k)), 1);
      @(posedge clk);
      #1;
      drive(k, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic reset_check_rr(string tag);
      check({tag, "_mem_en"},   32'(rr_mem_en), 0);
      check({tag, "_mem_rw"},   32'(rr_rw), 0);
      check({tag, "_mem_addr"}, 32'(rr_addr), 0);
      check({tag, "_mem_din"},  rr_din, 0);
      check({tag, "_p0_ack"},   32'(bus_rr.p0_ack), 0);
      check({tag, "_p1_ack"},   32'(bus_rr.p1_ack), 0);
      check({tag, "_p0_rdata"}, bus_rr.p0_rdata, 0);
      check({tag, "_p1_rdata"}, bus_rr.p1_rdata, 0);
      check({tag, "_busy"},     32'(rr_busy), 0);
      check({tag, "_grant"},    32'(rr_grant), 0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every ack pops the matching queue and checks data, timing, grant and busy.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (ack_of(k)) begin
            check($sformatf("ack_expected_k%0d", k), 32'(exp_q[k].size() > 0), 1);
            if (exp_q[k].size() > 0) begin
               exp_t e;
               e = exp_q[k].pop_front();
               check($sformatf("rdata_k%0d", k), rd_of(k), e.rdata);
               check($sformatf("ack_cycle_k%0d", k), 32'(cyc), 32'(e.due));
               check($sformatf("grant_k%0d", k), 32'((k < 2) ? rr_grant : fx_grant), 32'(k % 2));
               check($sformatf("busy_k%0d", k), 32'((k < 2) ? rr_busy : fx_busy), 1);
            end
         end
      end
      if (bus_rr.p0_ack) check("dual_ack_rr", 32'(bus_rr.p1_ack), 0);
      if (bus_fx.p0_ack) check("dual_ack_fx", 32'(bus_fx.p1_ack), 0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         rr_mem[i] = 32'hA5A5_0000 | 32'(i);
         fx_mem[i] = 32'hA5A5_0000 | 32'(i);
      end
      for (int k = 0; k < 4; k++) drive(k, 1'b0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      reset_check_rr("reset");
      check("reset_fx_mem_en", 32'(fx_mem_en), 0);
      check("reset_fx_busy",   32'(fx_busy), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Write then read back on port 0.
      txn(0, 1'b1, 12'h005, 32'hDEAD_BEEF, 32'h0, 3);
      txn(0, 1'b0, 12'h005, 32'h0, 32'hDEAD_BEEF, 3);

      // Simultaneous reads straight after reset: port 0 first, port 1 four cycles later.
      pulse_reset();
      fork
         txn(0, 1'b0, 12'h020, 32'h0, 32'hA5A5_0020, 3);
         txn(1, 1'b0, 12'h030, 32'h0, 32'hA5A5_0030, 7);
      join

      // Continuous contention: grants alternate 0,1,0,1...
      fork
         for (int i = 0; i < 4; i++)
            txn(0, 1'b0, AW'(64 + i), 32'h0, 32'hA5A5_0040 + i, (i == 0) ? 3 : 7);
         for (int i = 0; i < 4; i++)
            txn(1, 1'b0, AW'(80 + i), 32'h0, 32'hA5A5_0050 + i, 7);
      join

      // Same-address write/read race at the top address.
      fork
         txn(1, 1'b1, 12'hFFF, 32'h1234_5678, 32'hA5A5_0053, 7);
         txn(0, 1'b0, 12'hFFF, 32'h0, 32'hA5A5_0FFF, 3);
      join
      txn(0, 1'b0, 12'hFFF, 32'h0, 32'h1234_5678, 3);

      // Reset asserted during ISSUE of a write: aborted, no ack, memory untouched.
      drive(0, 1'b1, 1'b1, 12'h010, 32'hBAD0_BAD0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      reset_check_rr("abort");
      drive(0, 1'b0, 1'b0, '0, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      txn(0, 1'b0, 12'h010, 32'h0, 32'hA5A5_0010, 3);

      // Port 1 read, then writes only: its rdata must hold, never picking up Z.
      txn(1, 1'b0, 12'h030, 32'h0, 32'hA5A5_0030, 3);
      for (int i = 0; i < 3; i++)
         txn(1, 1'b1, AW'(96 + i), 32'hC0DE_0000 + i, 32'hA5A5_0030, 3);
      repeat (3) @(posedge clk);
      #1;
      check("p1_rdata_hold", bus_rr.p1_rdata, 32'hA5A5_0030);
      txn(0, 1'b0, 12'h061, 32'h0, 32'hC0DE_0001, 3);

      // Fixed priority: port 1 waits until port 0 stops requesting.
      fork
         for (int i = 0; i < 4; i++)
            txn(2, 1'b0, AW'(128 + i), 32'h0, 32'hA5A5_0080 + i, 3);
         txn(3, 1'b0, 12'h090, 32'h0, 32'hA5A5_0090, 19);
      join

      repeat (4) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
         check($sformatf("pending_k%0d", k), 32'(exp_q[k].size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
